// File: rtl/apb_master_nch_pkg.sv
// apb_pkg: FSM state and response codes shared by the APB bridge master.
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} apb_state_e;
  typedef enum logic [1:0] {OKAY, SLVERR, DECERR, TIMEOUT} apb_resp_e;
endpackage

// File: rtl/apb_master_nch_if.sv
// apb_master_nch_if: multi-slave APB3 bus, one PSEL/PREADY/PSLVERR bit and PRDATA slice per slave.
interface apb_master_nch_if #(
  parameter int NUM_SLAVES = 5,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic PWRITE;
  logic PENABLE;
  logic [NUM_SLAVES-1:0] PSEL;
  logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
  logic [NUM_SLAVES-1:0] PREADY;
  logic [NUM_SLAVES-1:0] PSLVERR;
  modport master(output PADDR, PWDATA, PWRITE, PENABLE, PSEL, input PRDATA, PREADY, PSLVERR);
  modport slave(input PADDR, PWDATA, PWRITE, PENABLE, PSEL, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_master_nch_addr_decode.sv
// apb_addr_decode: maps an address onto one of NUM_SLAVES equal, contiguous slots.
module apb_addr_decode #(
  parameter int NUM_SLAVES = 5,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1000_0000,
  parameter int SLOT_BITS = 12,
  parameter int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input logic [ADDR_W-1:0] addr,
  output logic hit,
  output logic [IDX_W-1:0] idx,
  output logic [NUM_SLAVES-1:0] onehot
);
  logic [ADDR_W-1:0] off, slot;
  assign off = addr - BASE_ADDR;
  assign slot = off >> SLOT_BITS;
  assign hit = addr >= BASE_ADDR && slot < ADDR_W'(NUM_SLAVES);
  assign idx = slot[IDX_W-1:0];
  assign onehot = hit ? NUM_SLAVES'(1) << idx : '0;
endmodule

// File: rtl/apb_master_nch.sv
// apb_master_nch: APB3 bridge master with decode-error, slave-error and ACCESS timeout responses.
module apb_master_nch #(
  parameter int NUM_SLAVES = 5,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h1000_0000,
  parameter int SLOT_BITS = 12,
  parameter int TIMEOUT = 16
) (
  input logic PCLK,
  input logic PRESET,
  apb_master_nch_if.master bus,
  input logic transfer,
  input logic [ADDR_W-1:0] addr,
  input logic [DATA_W-1:0] wdata,
  input logic write,
  output logic busy,
  output logic ready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0] resp
);
  import apb_pkg::*;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  apb_state_e state, state_n;
  apb_resp_e resp_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, prdata;
  logic [IDX_W-1:0] idx, idx_q;
  logic [NUM_SLAVES-1:0] onehot, sel_q;
  logic [CW-1:0] cnt;
  logic write_q, hit, accept, active, rdy, err, tmo;
  apb_addr_decode #(
    .NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .SLOT_BITS(SLOT_BITS), .IDX_W(IDX_W)
  ) u_dec (.addr(addr), .hit(hit), .idx(idx), .onehot(onehot));
  always_comb begin
    accept = state == IDLE && transfer;
    active = state == SETUP || state == ACCESS;
    rdy = bus.PREADY[idx_q];
    err = bus.PSLVERR[idx_q];
    prdata = bus.PRDATA[idx_q*DATA_W +: DATA_W];
    // cnt holds the ACCESS cycles already spent, so this is the TIMEOUT-th one
    tmo = TIMEOUT != 0 && cnt == LAST;
    state_n = state;
    case (state)
      IDLE: state_n = accept ? (hit ? SETUP : DONE) : IDLE;
      SETUP: state_n = ACCESS;
      ACCESS: state_n = (rdy || tmo) ? DONE : ACCESS;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      idx_q <= '0;
      sel_q <= '0;
      cnt <= '0;
      rdata_q <= '0;
      resp_q <= OKAY;
    end else begin
      state <= state_n;
      cnt <= state == ACCESS ? cnt + 1'b1 : '0;
      if (accept) begin
        addr_q <= addr;
        wdata_q <= wdata;
        write_q <= write;
        idx_q <= idx;
        sel_q <= onehot;
        if (!hit) resp_q <= DECERR;
      end
      if (state == ACCESS && rdy) begin
        if (!write_q) rdata_q <= prdata;
        resp_q <= err ? SLVERR : OKAY;
      end else if (state == ACCESS && tmo) begin
        rdata_q <= '0;
        resp_q <= apb_pkg::TIMEOUT;
      end
    end
  end
  assign bus.PADDR = addr_q;
  assign bus.PWDATA = wdata_q;
  assign bus.PWRITE = write_q && active;
  assign bus.PENABLE = state == ACCESS;
  assign bus.PSEL = active ? sel_q : '0;
  assign busy = active;
  assign ready = state == DONE;
  assign rdata = rdata_q;
  assign resp = resp_q;
endmodule

// File: tb/tb_apb_master_nch.sv
// tb_apb_master_nch: directed APB bridge scenarios with a response scoreboard checked on every ready pulse.
module tb_apb_master_nch;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  logic transfer = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic write = 1'b0;
  logic busy, ready;
  logic [31:0] rdata;
  logic [1:0] resp;
  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];
  logic [33:0] e;
  int wait_n = 0;
  int acc = 0;
  logic hang = 1'b0;
  logic slv_err = 1'b0;
  logic [31:0] rd_val = '0;
  always #5 PCLK = ~PCLK;
  apb_master_nch_if #(.NUM_SLAVES(5), .ADDR_W(32), .DATA_W(32)) bus ();
  apb_master_nch #(
    .NUM_SLAVES(5), .ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'h1000_0000), .SLOT_BITS(12), .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus), .transfer(transfer), .addr(addr), .wdata(wdata),
    .write(write), .busy(busy), .ready(ready), .rdata(rdata), .resp(resp)
  );
  // slave model: the selected slave answers after wait_n ACCESS cycles; unselected ones shout garbage
  always @(posedge PCLK) acc <= bus.PENABLE ? acc + 1 : 0;
  always_comb begin
    bus.PREADY = '1;
    bus.PSLVERR = '1;
    bus.PRDATA = '0;
    for (int s = 0; s < 5; s++) begin
      bus.PREADY[s] = bus.PSEL[s] ? (bus.PENABLE && acc >= wait_n && !hang) : 1'b1;
      bus.PSLVERR[s] = bus.PSEL[s] ? slv_err : 1'b1;
      bus.PRDATA[s*32 +: 32] = bus.PSEL[s] ? rd_val : (32'hBAD0_0000 | 32'(s));
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge PCLK) begin
    if (ready === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_ready", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("rdata", 64'(rdata), 64'(e[33:2]));
        chk("resp", 64'(resp), 64'(e[1:0]));
      end
    end
  end
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [4:0] sel,
                        input int lat, input logic [31:0] er, input logic [1:0] ersp, input logic hold);
    int n = 0;
    exp_q.push_back({er, ersp});
    @(posedge PCLK); #1;
    transfer = 1'b1; addr = a; wdata = d; write = w;
    @(negedge PCLK);
    while (ready !== 1'b1 && n < 40) begin
      if (n > 0) begin
        chk("busy", 64'(busy), 64'd1);
        chk("psel", 64'(bus.PSEL), 64'(sel));
        chk("penable", 64'(bus.PENABLE), 64'(n > 1));
        chk("paddr", 64'(bus.PADDR), 64'(a));
        chk("pwdata", 64'(bus.PWDATA), 64'(d));
        chk("pwrite", 64'(bus.PWRITE), 64'(w));
      end
      @(posedge PCLK); #1;
      if (!hold) transfer = 1'b0;
      addr = ~a; wdata = ~d;
      @(negedge PCLK);
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("done_psel", 64'(bus.PSEL), 64'd0);
    chk("done_busy", 64'(busy), 64'd0);
  endtask
  initial begin
    @(negedge PCLK);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_psel", 64'(bus.PSEL), 64'd0);
    chk("rst_penable", 64'(bus.PENABLE), 64'd0);
    chk("rst_pwrite", 64'(bus.PWRITE), 64'd0);
    chk("rst_paddr", 64'(bus.PADDR), 64'd0);
    chk("rst_pwdata", 64'(bus.PWDATA), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_resp", 64'(resp), 64'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    rd_val = 32'h5555_AAAA;
    do_req(32'h1000_2004, 32'hDEAD_BEEF, 1'b1, 5'b00100, 3, 32'h0, 2'd0, 1'b0);
    wait_n = 3; rd_val = 32'h1234_5678;
    do_req(32'h1000_4010, 32'h0, 1'b0, 5'b10000, 6, 32'h1234_5678, 2'd0, 1'b0);
    do_req(32'h1000_5000, 32'h0, 1'b0, 5'b00000, 1, 32'h1234_5678, 2'd2, 1'b0);
    do_req(32'h0FFF_FFFC, 32'h0, 1'b0, 5'b00000, 1, 32'h1234_5678, 2'd2, 1'b0);
    hang = 1'b1;
    do_req(32'h1000_1000, 32'h0, 1'b0, 5'b00010, 18, 32'h0, 2'd3, 1'b0);
    hang = 1'b0; wait_n = 15; rd_val = 32'h0BAD_F00D;
    do_req(32'h1000_1FFC, 32'h0, 1'b0, 5'b00010, 18, 32'h0BAD_F00D, 2'd0, 1'b0);
    wait_n = 0; slv_err = 1'b1; rd_val = 32'hCAFE_0001;
    do_req(32'h1000_0008, 32'h0, 1'b0, 5'b00001, 3, 32'hCAFE_0001, 2'd1, 1'b1);
    slv_err = 1'b0; wait_n = 1;
    do_req(32'h1000_4FFC, 32'h0102_0304, 1'b1, 5'b10000, 4, 32'hCAFE_0001, 2'd0, 1'b0);
    do_req(32'h1000_5000, 32'h0, 1'b0, 5'b00000, 1, 32'hCAFE_0001, 2'd2, 1'b0);
    hang = 1'b1;
    @(posedge PCLK); #1;
    transfer = 1'b1; addr = 32'h1000_3000; write = 1'b0;
    @(posedge PCLK); #1;
    transfer = 1'b0;
    @(posedge PCLK); #1;
    chk("pre_rst_penable", 64'(bus.PENABLE), 64'd1);
    PRESET = 1'b1;
    #1;
    chk("mid_rst_psel", 64'(bus.PSEL), 64'd0);
    chk("mid_rst_penable", 64'(bus.PENABLE), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(ready), 64'd0);
    chk("mid_rst_resp", 64'(resp), 64'd0);
    chk("mid_rst_rdata", 64'(rdata), 64'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0; hang = 1'b0; wait_n = 0;
    do_req(32'h1000_3000, 32'h0000_0077, 1'b1, 5'b01000, 3, 32'h0, 2'd0, 1'b0);
    repeat (3) @(negedge PCLK);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_master_nch.md
# apb_master_nch

Parametrised APB3 bridge master that turns single-cycle internal requests (`transfer`/`addr`/`wdata`/`write`) into SETUP/ACCESS bus transfers across NUM_SLAVES peripherals laid out in equal-size, contiguous address slots. It sits between the CPU-side bus interface and the peripheral APB slaves. It adds four things: PSLVERR capture, decode-error responses for unmapped addresses, an ACCESS-phase timeout, and a registered completion interface carrying a 2-bit response code.

## Interface
- NUM_SLAVES, 5: number of slave channels (1..16).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- BASE_ADDR, 32'h1000_0000: start of slot 0; aligned to 2^SLOT_BITS.
- SLOT_BITS, 12: log2 of slot size; slot i spans BASE_ADDR + i·2^SLOT_BITS.
- TIMEOUT, 16: maximum ACCESS cycles without PREADY; 0 disables the timeout.
- Clock and reset: one clock; reset is asynchronous and active-high.
- PCLK  in  1  clock.
- PRESET  in  1  async active-high reset.
- PADDR  out  ADDR_W  latched address.
- PWDATA  out  DATA_W  latched write data.
- PWRITE  out  1  direction; high only in SETUP/ACCESS of a write.
- PENABLE  out  1  high in ACCESS.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PRDATA  in  NUM_SLAVES×DATA_W  packed per-slave read data.
- PREADY  in  NUM_SLAVES  per-slave ready.
- PSLVERR  in  NUM_SLAVES  per-slave error.
- transfer  in  1  request strobe; sampled only when busy=0.
- addr  in  ADDR_W  request address.
- wdata  in  DATA_W  request write data.
- write  in  1  1 = write, 0 = read.
- busy  out  1  high from acceptance until the ready pulse.
- ready  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data; held until the next completion.
- resp  out  2  0 OKAY, 1 SLVERR, 2 DECERR, 3 TIMEOUT; held until the next completion.

## Operation
- **States:**
  - IDLE: on transfer=1, latch addr/wdata/write and the decode result.
    - Address hit → SETUP.
    - Address miss → DONE, with resp=DECERR and no PSEL asserted.
  - SETUP: assert PSEL[idx]; PENABLE=0; clear the wait counter. → ACCESS.
  - ACCESS: PSEL[idx]=1, PENABLE=1.
    - PREADY[idx]=1 → DONE. Capture PRDATA[idx] into rdata on reads (writes leave rdata unchanged). resp = PSLVERR[idx] ? SLVERR : OKAY.
    - Otherwise increment the counter. When TIMEOUT≠0 and the counter reaches TIMEOUT → DONE with resp=TIMEOUT and rdata=0.
  - DONE: ready=1, busy=0; PSEL and PENABLE are deasserted. → IDLE.
- **Decode:**
  - off = addr − BASE_ADDR.
  - hit = (addr ≥ BASE_ADDR) and (off >> SLOT_BITS) < NUM_SLAVES.
  - idx = off >> SLOT_BITS.
  - The decode is computed from the incoming request and registered at acceptance.
- **Request handling:**
  - transfer while busy=1 is ignored; it is not queued.
  - transfer asserted during the DONE cycle is ignored; the earliest acceptance is the cycle after ready.
- **Reset values:** all outputs are 0 and state is IDLE. PADDR/PWDATA outside a transfer show the last latched values.
- **Reset mid-transfer:** PSEL/PENABLE drop immediately, no ready pulse is produced, and rdata/resp are cleared.

## Timing
- Transfer accepted at cycle 0 → SETUP at 1, ACCESS at 2. If PREADY is high at cycle 2+w, ready pulses at cycle 3+w.
- Zero-wait read or write: 4 cycles from acceptance to the ready pulse (inclusive).
- Decode error: ready pulses at cycle 1 with resp=2.
- Timeout: ACCESS lasts exactly TIMEOUT cycles; ready pulses on the following cycle.
- PREADY sampled in the same cycle the counter reaches TIMEOUT: PREADY wins and resp is OKAY or SLVERR.
- PREADY/PSLVERR/PRDATA of non-selected slaves are ignored.
- PSLVERR is sampled only when PREADY[idx]=1.

## Structure
- **Package apb_pkg:**
  - `apb_state_e` {IDLE, SETUP, ACCESS, DONE}.
  - `apb_resp_e` {OKAY, SLVERR, DECERR, TIMEOUT}.
- **Sub-module apb_addr_decode:** parametrised by NUM_SLAVES/ADDR_W/BASE_ADDR/SLOT_BITS; outputs hit, idx, and a one-hot vector.
- **Top level:** FSM, latch registers, wait counter of width $clog2(TIMEOUT+1), and the per-channel read/ready/error mux indexed by the registered idx.

## Test plan
- Write 0x1000_2004 ← 0xDEADBEEF, slave 2 with zero wait states → PSEL=00100; PWRITE=1; PADDR/PWDATA stable through SETUP and ACCESS; ready at cycle 3; resp=0.
- Read 0x1000_4010, slave 4 returns 0x1234_5678 after 3 wait states → ready at cycle 6; rdata=0x1234_5678; resp=0.
- Read 0x1000_5000 (unmapped) → no PSEL asserted; ready at cycle 1; resp=2; rdata unchanged.
- Slave 1 holds PREADY=0 with TIMEOUT=16 → ACCESS lasts 16 cycles; ready follows; resp=3; rdata=0.
- Slave 0 returns PREADY=1 with PSLVERR=1 → resp=1. A transfer request during busy and during the DONE cycle is ignored; the next transfer is accepted the cycle after ready.
- PRESET asserted during ACCESS → PSEL, PENABLE, busy, resp and rdata are 0 immediately; no ready pulse; a normal transfer succeeds after release.
